// File: rtl/n64_vi_bus_demux_pkg.sv
// n64_vi_bus_demux_pkg: shared widths, vdata field slices, sync bit indices, FSM encoding, PAL threshold
// Optional feature macro used by the top: VI_DEMUX_PHASE_CHECK_EN
`define VDATA_SYNC (3*color_width_i+3) -: 4
`define VDATA_R (3*color_width_i-1) -: color_width_i
`define VDATA_G (2*color_width_i-1) -: color_width_i
`define VDATA_B (color_width_i-1) -: color_width_i
package n64_vi_bus_demux_pkg;
  localparam int color_width_i = 7;
  localparam int vdata_width = 4 + 3 * color_width_i;
  localparam int pal_line_threshold_dflt = 288;
  localparam int sync_nvsync = 3;
  localparam int sync_nclamp = 2;
  localparam int sync_nhsync = 1;
  localparam int sync_ncsync = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_RCAP, ST_GCAP, ST_BCAP} state_e;
endpackage

// File: rtl/n64_vi_bus_demux_if.sv
// n64_vi_bus_demux_if: VI bus in, demuxed pixel/sync/status out
// Ports: nDSYNC, VD_i (VI side); vdata_sync_valid_o, vdata_sync_o, vdata_valid_o, vdata_o,
//        palmode_o, interlaced_o, phase_err_o (demux side). slave = demux, master = driver/consumer.
interface n64_vi_bus_demux_if;
  import n64_vi_bus_demux_pkg::*;
  logic nDSYNC;
  logic [color_width_i-1:0] VD_i;
  logic vdata_sync_valid_o;
  logic [3:0] vdata_sync_o;
  logic vdata_valid_o;
  logic [vdata_width-1:0] vdata_o;
  logic palmode_o;
  logic interlaced_o;
  logic phase_err_o;
  modport slave (input nDSYNC, VD_i, output vdata_sync_valid_o, vdata_sync_o, vdata_valid_o, vdata_o, palmode_o, interlaced_o, phase_err_o);
  modport master (output nDSYNC, VD_i, input vdata_sync_valid_o, vdata_sync_o, vdata_valid_o, vdata_o, palmode_o, interlaced_o, phase_err_o);
endinterface

// File: rtl/n64_vi_bus_demux_field_meas.sv
// n64_field_meas: counts nHSYNC falls per field, decides PAL and interlaced at each nVSYNC fall
// Ports: VCLK, nRST (async active-low), i_sync_valid (sync strobe), i_sync ({nVSYNC,nCLAMP,nHSYNC,nCSYNC}),
//        o_palmode, o_interlaced (updated only at field end)
module n64_field_meas
  import n64_vi_bus_demux_pkg::*;
#(
  parameter int pal_line_threshold = pal_line_threshold_dflt
) (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       i_sync_valid,
  input  logic [3:0] i_sync,
  output logic       o_palmode,
  output logic       o_interlaced
);
  localparam logic [9:0] thr = 10'(pal_line_threshold);
  logic [3:0] r_prev_sync;
  logic [9:0] r_linecnt, r_prev_linecnt;
  logic r_palmode, r_interlaced;
  logic w_hfall, w_vfall;
  assign w_hfall = r_prev_sync[sync_nhsync] & ~i_sync[sync_nhsync];
  assign w_vfall = r_prev_sync[sync_nvsync] & ~i_sync[sync_nvsync];
  always_ff @(posedge VCLK or negedge nRST)
    if (!nRST) begin
      r_prev_sync <= 4'h0;
      r_linecnt <= '0;
      r_prev_linecnt <= '0;
      r_palmode <= 1'b0;
      r_interlaced <= 1'b0;
    end else if (i_sync_valid) begin
      r_prev_sync <= i_sync;
      // field end takes priority so a word with both edges clears rather than counts
      if (w_vfall) begin
        r_palmode <= r_linecnt >= thr;
        r_interlaced <= r_linecnt != r_prev_linecnt;
        r_prev_linecnt <= r_linecnt;
        r_linecnt <= '0;
      end else if (w_hfall && r_linecnt != 10'h3FF)
        r_linecnt <= r_linecnt + 10'd1;
    end
  assign o_palmode = r_palmode;
  assign o_interlaced = r_interlaced;
endmodule

// File: rtl/n64_vi_bus_demux.sv
// n64_vi_bus_demux: samples the VI bus and splits sync/R/G/B words into a sync strobe and an assembled pixel
// Ports: VCLK, nRST (async active-low), bus (n64_vi_bus_demux_if.slave)
// Optional: define VI_DEMUX_PHASE_CHECK_EN for the sticky phase_err_o (short pixel / long idle gap)
module n64_vi_bus_demux
  import n64_vi_bus_demux_pkg::*;
#(
  parameter int pal_line_threshold = pal_line_threshold_dflt
) (
  input logic VCLK,
  input logic nRST,
  n64_vi_bus_demux_if.slave bus
);
  state_e r_state;
  logic r_ndsync_q;
  logic [color_width_i-1:0] r_vd_q, r_r, r_g;
  logic r_sync_valid, r_valid;
  logic [3:0] r_sync;
  logic [vdata_width-1:0] r_vdata;
  // nDSYNC_q resets high so releasing reset never fakes a sync capture
  always_ff @(posedge VCLK or negedge nRST)
    if (!nRST) begin
      r_state <= ST_IDLE;
      r_ndsync_q <= 1'b1;
      r_vd_q <= '0;
      r_r <= '0;
      r_g <= '0;
      r_sync_valid <= 1'b0;
      r_valid <= 1'b0;
      r_sync <= 4'h0;
      r_vdata <= '0;
    end else begin
      r_ndsync_q <= bus.nDSYNC;
      r_vd_q <= bus.VD_i;
      r_sync_valid <= 1'b0;
      r_valid <= 1'b0;
      if (!r_ndsync_q) begin
        r_sync <= r_vd_q[3:0];
        r_sync_valid <= 1'b1;
        r_state <= ST_RCAP;
      end else
        case (r_state)
          ST_RCAP: begin
            r_r <= r_vd_q;
            r_state <= ST_GCAP;
          end
          ST_GCAP: begin
            r_g <= r_vd_q;
            r_state <= ST_BCAP;
          end
          ST_BCAP: begin
            r_vdata <= {r_sync, r_r, r_g, r_vd_q};
            r_valid <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
    end
`ifdef VI_DEMUX_PHASE_CHECK_EN
  logic r_phase_err, r_gap;
  always_ff @(posedge VCLK or negedge nRST)
    if (!nRST) begin
      r_phase_err <= 1'b0;
      r_gap <= 1'b0;
    end else begin
      r_gap <= r_state == ST_IDLE && r_ndsync_q;
      if ((!r_ndsync_q && (r_state == ST_RCAP || r_state == ST_GCAP)) || (r_state == ST_IDLE && r_ndsync_q && r_gap))
        r_phase_err <= 1'b1;
    end
  assign bus.phase_err_o = r_phase_err;
`else
  assign bus.phase_err_o = 1'b0;
`endif
  n64_field_meas #(.pal_line_threshold(pal_line_threshold)) u_meas (
    .VCLK(VCLK),
    .nRST(nRST),
    .i_sync_valid(r_sync_valid),
    .i_sync(r_sync),
    .o_palmode(bus.palmode_o),
    .o_interlaced(bus.interlaced_o)
  );
  assign bus.vdata_sync_valid_o = r_sync_valid;
  assign bus.vdata_sync_o = r_sync;
  assign bus.vdata_valid_o = r_valid;
  assign bus.vdata_o = r_vdata;
endmodule

// File: doc/n64_vi_bus_demux.md
Name: n64_vi_bus_demux

Overview:
- Front-end stage of the PPU: samples the N64 VI bus (7-bit VD + nDSYNC) on VCLK and splits the 4-word pixel sequence (sync, R, G, B).
- Emits a per-pixel sync strobe/word and the assembled pixel. These drive the test-pattern generator's sync/valid inputs directly downstream.
- Also measures lines per field to report PAL/NTSC and interlaced/progressive.

Parameters:
- color_width_i, 7, bits per colour component on VD and in vdata_o.
- pal_line_threshold, 288, lines per field at or above which the input is PAL.

Ports:
- VCLK  in  1  video clock.
- nRST  in  1  asynchronous, active-low reset.
- nDSYNC  in  1  VI bus word-sync, low marks the sync word.
- VD_i  in  color_width_i  VI data bus.
- vdata_sync_valid_o  out  1  one-cycle strobe, sync word captured.
- vdata_sync_o  out  4  {nVSYNC, nCLAMP, nHSYNC, nCSYNC} from the last sync word.
- vdata_valid_o  out  1  one-cycle strobe, full pixel assembled.
- vdata_o  out  4+3*color_width_i  {sync[3:0], R, G, B}.
- palmode_o  out  1  1 = PAL field length detected.
- interlaced_o  out  1  1 = consecutive field lengths differ.
- phase_err_o  out  1  sticky phase-error flag (see Optional Feature).

Behaviour:
- Reset (async, nRST low):
  - All outputs 0, FSM in IDLE, line counters 0.
  - Previous-sync register = 4'h0, so no edge is detected on the first word.
- Input stage: nDSYNC and VD_i are registered once (nDSYNC_q, VD_q). All decoding uses the _q versions.
- FSM states: IDLE, RCAP, GCAP, BCAP.
  - Any state, nDSYNC_q low: capture VD_q[3:0] into vdata_sync_o, pulse vdata_sync_valid_o, go to RCAP.
  - RCAP, nDSYNC_q high: latch R, go to GCAP.
  - GCAP, nDSYNC_q high: latch G, go to BCAP.
  - BCAP, nDSYNC_q high: latch B, write {sync, R, G, B} to vdata_o, pulse vdata_valid_o, go to IDLE.
  - IDLE, nDSYNC_q high: stay in IDLE, no strobes.
- Latency:
  - vdata_sync_valid_o rises 2 VCLK edges after nDSYNC low is present on the pins.
  - vdata_valid_o rises 2 edges after the B word is present on the pins, i.e. 3 cycles after vdata_sync_valid_o.
- Output hold: vdata_o and vdata_sync_o hold their values between strobes. The strobes are never high in the same cycle.
- Early nDSYNC low in RCAP/GCAP/BCAP:
  - Partial pixel discarded; vdata_o unchanged, no vdata_valid_o pulse.
  - New sync word accepted normally.
- Line counter (10 bit, saturates at 1023), updated on each sync-word capture:
  - Falling nHSYNC versus previous sync word: increment.
  - Falling nVSYNC versus previous sync word: end of field (below).
  - Both edges in the same word: nVSYNC handling wins and the counter clears to 0.
- End of field:
  - palmode_o <= (linecnt >= pal_line_threshold).
  - interlaced_o <= (linecnt != prev_field_linecnt).
  - prev_field_linecnt <= linecnt; linecnt <= 0.
  - palmode_o and interlaced_o change only at field end.
- Reset mid-pixel: immediate return to reset values. The first field after reset reports the length counted from reset, so its flags are provisional; flags are valid from the second field.

Optional Feature:
- Macro: VI_DEMUX_PHASE_CHECK_EN.
- Defined:
  - phase_err_o sets when nDSYNC_q is low in RCAP or GCAP (a short pixel).
  - phase_err_o also sets when nDSYNC_q is high in IDLE for more than 1 consecutive cycle (a long gap).
  - It stays set until nRST.
- Undefined: phase_err_o tied to 0, checking logic absent; FSM behaviour is identical.

Decomposition:
- Shared package / vh header:
  - color_width_i and vdata width.
  - Slice macros for the sync, R, G and B fields.
  - Sync bit indices: nVSYNC = 3, nCLAMP = 2, nHSYNC = 1, nCSYNC = 0.
  - FSM state encoding.
  - Default PAL threshold.
- One natural sub-module: n64_field_meas (line counter, PAL/interlace decision), fed by the sync strobe and sync word.

Test Plan:
- Nominal pixel:
  - Stimulus: nDSYNC low with VD=7'h0F, then R=7'h55, G=7'h2A, B=7'h7F.
  - Required: vdata_sync_valid_o pulses with sync=4'hF; 3 cycles later vdata_valid_o pulses with vdata_o={4'hF,7'h55,7'h2A,7'h7F}.
- Short pixel:
  - Stimulus: nDSYNC low again in GCAP.
  - Required: no vdata_valid_o, vdata_o unchanged, new sync strobe. With VI_DEMUX_PHASE_CHECK_EN, phase_err_o=1 and stays set.
- PAL field:
  - Stimulus: 2 fields of 312 nHSYNC falls each.
  - Required: after the second nVSYNC fall, palmode_o=1, interlaced_o=0.
- NTSC interlaced:
  - Stimulus: fields of 262 and 263 lines alternating.
  - Required: palmode_o=0, interlaced_o=1 from the second field on.
- Reset mid-pixel:
  - Stimulus: nRST low while in BCAP.
  - Required: all outputs 0 at once; after release, no strobe until the next nDSYNC low.
- Counter saturation:
  - Stimulus: 1100 HSYNC falls without VSYNC.
  - Required: count holds 1023; at the next VSYNC, palmode_o=1.
